// File: rtl/avalon_slave_pkg.sv
// Shared types and constants for the Avalon-MM memory slave: FSM states,
// wait-counter width and the wait-jitter LFSR seed/taps.
package avalon_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int         CNT_W      = 4;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;

endpackage

// File: rtl/avs_byte_ram.sv
// Word-addressed RAM with byte write enables and a registered read port.
// One-cycle read latency; no flow control, write and read ports are independent.
module avs_byte_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_q
);

    logic [31:0] mem [WORDS];

    // Contents are deliberately not reset so a reset never disturbs stored data.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata_q <= mem[raddr];
    end

endmodule

// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory slave: WAIT_CYCLES+1 cycles request-to-ack (jittered when AVS_RANDOM_WAIT_EN
// is defined), waitrequest held high until the single ACK cycle; writes commit on leaving ACK.
module avalon_mem_slave
    import avalon_slave_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'hBFC00000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        access_error
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d, load_cnt;
    logic [IDX_W-1:0]   idx_q, idx_d, live_idx, ram_raddr;
    logic               rng_q, rng_d, live_rng;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               access_error_q, access_error_d;
    logic [31:0]        offset, ram_rdata;
    logic               accept, both_req, ram_we;
    logic               unused_offset_lsbs;

    assign offset             = avs_address - MEM_BASE;
    assign live_idx           = offset[IDX_W+1:2];
    assign live_rng           = ({2'b00, offset[31:2]} < 32'(MEM_WORDS));
    assign unused_offset_lsbs = ^offset[1:0];

    assign accept   = (state_q == IDLE) && (avs_read ^ avs_write);
    assign both_req = (state_q == IDLE) && avs_read && avs_write;

`ifdef AVS_RANDOM_WAIT_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [4:0] cnt_sum;

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign cnt_sum  = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
    assign load_cnt = (cnt_sum > 5'd15) ? 4'hF : cnt_sum[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end
`else
    assign load_cnt = CNT_W'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            idx_q          <= '0;
            rng_q          <= 1'b0;
            wr_q           <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            access_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            idx_q          <= idx_d;
            rng_q          <= rng_d;
            wr_q           <= wr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            access_error_q <= access_error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wait_cnt_d = load_cnt;
                    state_d    = (load_cnt == '0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - CNT_W'(1);
                if (wait_cnt_q <= CNT_W'(1)) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture; an error flagged here is visible during the cycle the FSM enters.
    always_comb begin
        idx_d   = accept ? live_idx       : idx_q;
        rng_d   = accept ? live_rng       : rng_q;
        wr_d    = accept ? avs_write      : wr_q;
        wdata_d = accept ? avs_writedata  : wdata_q;
        be_d    = accept ? avs_byteenable : be_q;
        access_error_d = both_req || ((state_d == ACK) && !rng_d);
    end

    always_comb begin
        avs_waitrequest = (state_q != ACK);
        access_error    = access_error_q;
        avs_readdata    = ((state_q == ACK) && !wr_q && rng_q) ? ram_rdata : 32'h0;
        ram_we          = (state_q == ACK) && wr_q && rng_q;
        // Live index in IDLE so a zero-wait read has its data by the ACK cycle.
        ram_raddr       = (state_q == IDLE) ? live_idx : idx_q;
    end

    avs_byte_ram #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .be      (be_q),
        .waddr   (idx_q),
        .wdata   (wdata_q),
        .raddr   (ram_raddr),
        .rdata_q (ram_rdata)
    );

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Scoreboard bench: directed transfers push expected ACK contents; a negedge monitor checks them.
module tb_avalon_mem_slave;

    localparam logic [31:0] BASE    = 32'hBFC00000;
    localparam int          WAIT_HI = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] avs_address, avs_writedata, avs_readdata;
    logic        avs_read, avs_write, avs_waitrequest, access_error;
    logic [3:0]  avs_byteenable;

    logic [31:0] r1_address, r1_readdata;
    logic        r1_read, r1_waitrequest, r1_error;

    always #5 clk = ~clk;

    avalon_mem_slave #(.MEM_BASE(BASE), .MEM_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest), .access_error(access_error)
    );

    avalon_mem_slave #(.MEM_BASE(BASE), .MEM_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .avs_address(r1_address), .avs_read(r1_read),
        .avs_write(1'b0), .avs_writedata(32'h0), .avs_byteenable(4'h0),
        .avs_readdata(r1_readdata), .avs_waitrequest(r1_waitrequest), .access_error(r1_error)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          hi;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hi_cnt = 0;
    int   err_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ACK cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            hi_cnt = 0;
        end else if (!avs_waitrequest) begin
            chk("ack_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.nm, "_rdata"}, avs_readdata, e.rd);
                chk({e.nm, "_err"}, {31'b0, access_error}, {31'b0, e.err});
                chk({e.nm, "_wait_hi"}, hi_cnt, e.hi);
            end
            hi_cnt = 0;
        end else begin
            if (access_error) err_pulses++;
            if (avs_read || avs_write) hi_cnt++;
            else                       hi_cnt = 0;
        end
    end

    task automatic xfer(input string nm, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input bit exp_err,
                        input bit perturb);
        exp_q.push_back('{exp_rd, exp_err, WAIT_HI, nm});
        @(posedge clk) #1;
        avs_read = !wr; avs_write = wr; avs_address = a; avs_writedata = wd; avs_byteenable = be;
        if (perturb) begin
            @(posedge clk) #1;
            avs_address = a ^ 32'h00000FF0; avs_writedata = ~wd; avs_byteenable = ~be;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!avs_waitrequest) break;
        end
        chk({nm, "_ack_seen"}, {31'b0, avs_waitrequest}, 32'd0);
        @(posedge clk) #1;
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi;
        int nreads;
        reset_n = 1'b0;
        avs_address = '0; avs_writedata = '0; avs_byteenable = '0; avs_read = 1'b0; avs_write = 1'b0;
        r1_address = '0; r1_read = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_access_error", {31'b0, access_error}, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        xfer("wr_full",   1, BASE + 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        0, 0);
        xfer("rd_full",   0, BASE + 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 0);
        xfer("wr_low2",   1, BASE + 32'h10, 32'h00001234, 4'b0011, 32'h0,        0, 0);
        xfer("rd_low2",   0, BASE + 32'h10, 32'h0,        4'b0000, 32'hDEAD1234, 0, 0);
        xfer("wr_b3",     1, BASE + 32'h10, 32'hAABBCCDD, 4'b1000, 32'h0,        0, 0);
        xfer("rd_b3",     0, BASE + 32'h10, 32'h0,        4'b0000, 32'hAAAD1234, 0, 0);
        xfer("rd_oor0",   0, 32'h00000000,  32'h0,        4'b0000, 32'h0,        1, 0);
        xfer("wr_oor",    1, BASE + 32'h1010, 32'hFFFFFFFF, 4'b1111, 32'h0,      1, 0);
        xfer("rd_alias",  0, BASE + 32'h10, 32'h0,        4'b0000, 32'hAAAD1234, 0, 0);
        xfer("wr_top",    1, BASE + 32'hFFC, 32'h0BADF00D, 4'b1111, 32'h0,       0, 0);
        xfer("rd_top",    0, BASE + 32'hFFC, 32'h0,       4'b0000, 32'h0BADF00D, 0, 0);
        xfer("rd_below",  0, BASE - 32'h4,  32'h0,        4'b0000, 32'h0,        1, 0);
        xfer("rd_pert",   0, BASE + 32'h10, 32'h0,        4'b0000, 32'hAAAD1234, 0, 1);
        xfer("wr_pert",   1, BASE + 32'h10, 32'h11223344, 4'b0100, 32'h0,        0, 1);
        xfer("rd_pert2",  0, BASE + 32'h10, 32'h0,        4'b0000, 32'hAA221234, 0, 0);

        // Read and write together must be rejected without touching memory.
        @(posedge clk) #1;
        err_pulses = 0;
        avs_read = 1'b1; avs_write = 1'b1; avs_address = BASE + 32'h10;
        avs_writedata = 32'hFFFFFFFF; avs_byteenable = 4'b1111;
        @(posedge clk) #1;
        avs_read = 1'b0; avs_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("both_err_pulses", err_pulses, 1);
        xfer("rd_after_both", 0, BASE + 32'h10, 32'h0, 4'b0000, 32'hAA221234, 0, 0);

        // Reset in the middle of a write must not commit it.
        xfer("wr_prior", 1, BASE + 32'h20, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 0);
        @(posedge clk) #1;
        avs_write = 1'b1; avs_address = BASE + 32'h20; avs_writedata = 32'h55555555;
        avs_byteenable = 4'b1111;
        @(posedge clk) #1;
        @(negedge clk) #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
        chk("midrst_readdata", avs_readdata, 32'h0);
        chk("midrst_access_error", {31'b0, access_error}, 32'd0);
        avs_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        xfer("rd_prior", 0, BASE + 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 0);

        // Zero-wait instance: one waitrequest-high cycle per read (1..4 with jitter).
`ifdef AVS_RANDOM_WAIT_EN
        nreads = 100;
`else
        nreads = 4;
`endif
        for (int i = 0; i < nreads; i++) begin
            @(posedge clk) #1;
            r1_read = 1'b1;
            r1_address = (i == 0) ? 32'h0 : BASE + 32'(i * 4);
            hi = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (r1_waitrequest) hi++;
                else break;
            end
            chk("zw_ack_seen", {31'b0, r1_waitrequest}, 32'd0);
`ifdef AVS_RANDOM_WAIT_EN
            chk("zw_hi_range", (hi >= 1 && hi <= 4) ? 32'd1 : 32'd0, 32'd1);
`else
            chk("zw_hi", hi, 1);
`endif
            if (i == 0) begin
                chk("zw_oor_rdata", r1_readdata, 32'h0);
                chk("zw_oor_err", {31'b0, r1_error}, 32'd1);
            end
            @(posedge clk) #1;
            r1_read = 1'b0;
        end

        repeat (3) @(posedge clk);
        chk("pending_expects", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_mem_slave.md
AVALON_MEM_SLAVE -- requirements
Module: avalon_mem_slave

Interface
REQ-001 Parameter MEM_BASE, default 32'hBFC00000; byte address of word 0 of the internal memory.
REQ-002 Parameter MEM_WORDS, default 1024; number of 32-bit words; power of two.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15; base wait-state count per transfer.
REQ-004 clk  in  1  the single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 avs_address  in  32  byte address; bits [1:0] ignored.
REQ-007 avs_read  in  1  read request.
REQ-008 avs_write  in  1  write request.
REQ-009 avs_writedata  in  32  write data.
REQ-010 avs_byteenable  in  4  per-byte write enable; bit n gates bits [8n+7:8n].
REQ-011 avs_readdata  out  32  read data; valid only while avs_waitrequest is low after a read.
REQ-012 avs_waitrequest  out  1  high = request not yet completed; master holds request stable.
REQ-013 access_error  out  1  one-cycle pulse on a rejected or out-of-range request.

Function
REQ-014 States: IDLE, WAIT, ACK; 4-bit down-counter wait_cnt.
REQ-015 avs_waitrequest shall be low only in ACK; high in IDLE, WAIT, and during reset.
REQ-016 IDLE, exactly one of read/write high at edge: capture address, writedata, byteenable, direction; load wait_cnt; go WAIT, or go ACK if the loaded count is 0.
REQ-017 IDLE, read and write both high: no transfer; access_error pulses next cycle; stay IDLE.
REQ-018 WAIT: decrement wait_cnt each edge; go ACK on the edge where wait_cnt is 1.
REQ-019 ACK lasts exactly one cycle, then IDLE; back-to-back requests therefore see at least one waitrequest-high cycle.
REQ-020 Read: avs_readdata shall be registered, holding the addressed word throughout ACK; 32'h0 at all other times.
REQ-021 Write: commit at the ACK-exit edge, only the bytes with byteenable set; other bytes unchanged.
REQ-022 Word index = (captured address - MEM_BASE) >> 2; in range iff the index < MEM_WORDS.
REQ-023 Out of range: the transfer still completes with normal timing; read returns 32'h0; write is dropped; access_error pulses during ACK.
REQ-024 Inputs changing during WAIT/ACK are ignored; captured values are used.
REQ-025 Total latency from request edge to waitrequest low shall be wait_cnt + 1 cycles (1 cycle when the count is 0).

Reset
REQ-026 Assertion of reset_n: immediately enter IDLE; wait_cnt = 0; avs_waitrequest = 1; avs_readdata = 0; access_error = 0.
REQ-027 Reset mid-transfer: no write committed; memory contents not reset.

Configuration
REQ-028 Macro AVS_RANDOM_WAIT_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances each accepted request; loaded wait_cnt = WAIT_CYCLES + lfsr[1:0], saturating at 15.
REQ-029 Macro AVS_RANDOM_WAIT_EN undefined: loaded wait_cnt = WAIT_CYCLES exactly; no LFSR logic.

Structure
REQ-030 Package avalon_slave_pkg holds the state_t enum (IDLE, WAIT, ACK), the LFSR seed and tap constants, and the wait-count width.
REQ-031 Sub-module avs_byte_ram: MEM_WORDS x 32 array, synchronous read, per-byte write enables; instantiated once.

Verification
REQ-032 WAIT_CYCLES=2: write 32'hDEADBEEF to 32'hBFC00010 with be 4'b1111, then read -> waitrequest high 3 cycles, low 1 cycle; readdata 32'hDEADBEEF in ACK.
REQ-033 After REQ-032, write 32'h00001234 with be 4'b0011, then read -> 32'hDEAD1234.
REQ-034 Read 32'h00000000 (out of range) -> normal timing; readdata 0; access_error 1 in ACK.
REQ-035 read=write=1 in IDLE -> waitrequest stays high; access_error pulses once; memory unchanged.
REQ-036 reset_n low in WAIT of a write to 32'hBFC00020 -> waitrequest 1 immediately; a later read of 32'hBFC00020 returns the prior contents.
REQ-037 WAIT_CYCLES=0, no macro: read -> waitrequest low on the first cycle after the request edge; with AVS_RANDOM_WAIT_EN, 100 reads each show 1..4 high cycles.
